// File: rtl/sum_hub_pkg.sv
// Shared types and helpers for the cross-core normalisation-sum exchange hub.
package sum_hub_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REDUCE  = 2'd2,
    BCAST   = 2'd3
  } hub_state_e;

  localparam logic MODE_GLOBAL = 1'b0;
  localparam logic MODE_PAIR   = 1'b1;

  // Growth bits cover the sum of ncore full-range partial sums.
  function automatic int tot_width(input int ncore, input int bw_sum);
    return bw_sum + $clog2(ncore);
  endfunction

endpackage

// File: rtl/sum_hub_acc.sv
// Sequential reducer: walks one slot per cycle into a global and a per-pair accumulator.
module sum_hub_acc
  import sum_hub_pkg::*;
#(
  parameter int NCORE  = 2,
  parameter int BW_TOT = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clr_i,
  input  logic                              run_i,
  input  logic [NCORE-1:0]                  en_i,
  input  logic [NCORE*BW_TOT-1:0]           slots_i,
  output logic [BW_TOT-1:0]                 acc_g_o,
  output logic [((NCORE+1)/2)*BW_TOT-1:0]   acc_p_o,
  output logic                              done_o
);

  localparam int NPAIR = (NCORE + 1) / 2;
  localparam int IDXW  = $clog2(NCORE);

  logic [IDXW-1:0]         idx_q, idx_d;
  logic [BW_TOT-1:0]       acc_g_q, acc_g_d;
  logic [NPAIR*BW_TOT-1:0] acc_p_q, acc_p_d;
  logic [BW_TOT-1:0]       add_s;
  logic                    last_s;

  // Outputs are the next-state sums so the final slot is included on the done edge.
  always_comb begin
    add_s = '0;
    for (int i = 0; i < NCORE; i++) begin
      add_s = add_s | (((idx_q == IDXW'(i)) && en_i[i]) ? slots_i[i*BW_TOT +: BW_TOT] : '0);
    end
    last_s  = run_i && (idx_q == IDXW'(NCORE - 1));
    idx_d   = idx_q;
    acc_g_d = acc_g_q;
    acc_p_d = acc_p_q;
    if (clr_i) begin
      idx_d   = '0;
      acc_g_d = '0;
      acc_p_d = '0;
    end else if (run_i) begin
      idx_d   = last_s ? '0 : idx_q + IDXW'(1);
      acc_g_d = acc_g_q + add_s;
      for (int p = 0; p < NPAIR; p++) begin
        acc_p_d[p*BW_TOT +: BW_TOT] = acc_p_q[p*BW_TOT +: BW_TOT] +
                                      (((idx_q >> 1) == IDXW'(p)) ? add_s : '0);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      acc_g_q <= '0;
      acc_p_q <= '0;
    end else begin
      idx_q   <= idx_d;
      acc_g_q <= acc_g_d;
      acc_p_q <= acc_p_d;
    end
  end

  assign acc_g_o = acc_g_d;
  assign acc_p_o = acc_p_d;
  assign done_o  = last_s;

endmodule

// File: rtl/sum_exchange_hub.sv
// Multi-core partial-sum exchange: collect per-core sums, reduce, broadcast totals back.
module sum_exchange_hub
  import sum_hub_pkg::*;
#(
  parameter int NCORE  = 2,
  parameter int BW_SUM = 23,
  parameter int BW_TOT = tot_width(NCORE, BW_SUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [NCORE-1:0]        en_mask,
  input  logic [NCORE*BW_SUM-1:0] sum_in,
  input  logic [NCORE-1:0]        sum_valid,
  output logic [NCORE-1:0]        sum_ready,
  output logic [NCORE*BW_TOT-1:0] tot_out,
  output logic [NCORE-1:0]        tot_valid,
  input  logic [NCORE-1:0]        tot_ack,
  output logic                    busy
);

  localparam int NPAIR = (NCORE + 1) / 2;

  hub_state_e              state_q;
  logic                    mode_q;
  logic                    busy_q;
  logic [NCORE-1:0]        en_q, got_q, tot_valid_q;
  logic [NCORE*BW_TOT-1:0] slot_q, tot_q;

  logic [NCORE-1:0]        ready_s, hs_s, got_nxt_s, vld_nxt_s;
  logic [NCORE*BW_TOT-1:0] slot_ext_s, tot_nxt_s;
  logic                    clr_s, run_s, done_s;
  logic [BW_TOT-1:0]       acc_g_s;
  logic [NPAIR*BW_TOT-1:0] acc_p_s;

  sum_hub_acc #(
    .NCORE  (NCORE),
    .BW_TOT (BW_TOT)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr_s),
    .run_i   (run_s),
    .en_i    (en_q),
    .slots_i (slot_q),
    .acc_g_o (acc_g_s),
    .acc_p_o (acc_p_s),
    .done_o  (done_s)
  );

  // Handshake qualification, sign extension and total selection.
  always_comb begin
    ready_s   = (state_q == COLLECT) ? (en_q & ~got_q) : '0;
    hs_s      = sum_valid & ready_s;
    got_nxt_s = got_q | hs_s;
    vld_nxt_s = tot_valid_q & ~tot_ack;
    clr_s     = (state_q == IDLE) && start && (|en_mask);
    run_s     = (state_q == REDUCE);
    for (int i = 0; i < NCORE; i++) begin
      slot_ext_s[i*BW_TOT +: BW_TOT] = {{(BW_TOT-BW_SUM){sum_in[i*BW_SUM + BW_SUM - 1]}},
                                        sum_in[i*BW_SUM +: BW_SUM]};
      tot_nxt_s[i*BW_TOT +: BW_TOT]  = (mode_q == MODE_PAIR) ? acc_p_s[(i/2)*BW_TOT +: BW_TOT]
                                                             : acc_g_s;
    end
  end

  // Round control FSM with registered totals, valids and busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_GLOBAL;
      busy_q      <= 1'b0;
      en_q        <= '0;
      got_q       <= '0;
      tot_valid_q <= '0;
      slot_q      <= '0;
      tot_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_s) begin
            mode_q  <= mode;
            en_q    <= en_mask;
            got_q   <= '0;
            slot_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          for (int i = 0; i < NCORE; i++) begin
            if (hs_s[i]) begin
              slot_q[i*BW_TOT +: BW_TOT] <= slot_ext_s[i*BW_TOT +: BW_TOT];
            end
          end
          got_q <= got_nxt_s;
          if (got_nxt_s == en_q) begin
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          if (done_s) begin
            tot_q       <= tot_nxt_s;
            tot_valid_q <= en_q;
            state_q     <= BCAST;
          end
        end
        BCAST: begin
          tot_valid_q <= vld_nxt_s;
          if (vld_nxt_s == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q      <= 1'b0;
          tot_valid_q <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign sum_ready = ready_s;
  assign tot_out   = tot_q;
  assign tot_valid = tot_valid_q;
  assign busy      = busy_q;

endmodule
